// File: rtl/matrix_pkg.sv
// Shared types and sizing helpers for the matrix output buffer.
package matrix_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_ROWS   = 4;

  typedef logic [DEF_WORD_W-1:0] row_t;

  // Index width that stays legal for a single-entry range.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mof_ram.sv
// Row storage: one synchronous write port, asynchronous read.
module mof_ram #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/matrix_out_fifo.sv
// Row FIFO behind the transposer; tags the last row of each
// matrix and can hold rows back until a matrix is complete.
module matrix_out_fifo
  import matrix_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int ROWS      = DEF_ROWS,
  parameter int DEPTH     = 8,
  parameter int STORE_FWD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WORD_W-1:0]        m2f_data,
  input  logic                     m2f_valid,
  output logic                     f2m_ready,
  output logic [WORD_W-1:0]        f_data,
  output logic                     f_valid,
  output logic                     f_last,
  input  logic                     f_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   matrix_cnt
);

  localparam int AW = ptr_w(DEPTH);
  localparam int RW = ptr_w(ROWS);
  localparam int LW = $clog2(DEPTH) + 1;

  if ((DEPTH < ROWS) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("matrix_out_fifo: DEPTH must be a power of 2 and >= ROWS");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] wr_row;
  logic [RW-1:0] rd_row;
  logic [LW-1:0] lvl_q;
  logic [LW-1:0] mcnt_q;
  logic          push;
  logic          pop;
  logic          wr_done;
  logic          rd_done;

  assign f2m_ready  = ~rst & (lvl_q != LW'(DEPTH));
  assign f_valid    = (STORE_FWD != 0) ? (mcnt_q != '0)
                                       : (lvl_q != '0);
  assign f_last     = f_valid & (rd_row == RW'(ROWS - 1));
  assign push       = m2f_valid & f2m_ready;
  assign pop        = f_valid & f_ready;
  assign wr_done    = push & (wr_row == RW'(ROWS - 1));
  assign rd_done    = pop & f_last;
  assign level      = lvl_q;
  assign matrix_cnt = mcnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wr_row <= '0;
      rd_row <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        wr_row <= (wr_row == RW'(ROWS - 1)) ? '0 : wr_row + RW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        rd_row <= (rd_row == RW'(ROWS - 1)) ? '0 : rd_row + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= '0;
    end else begin
      unique case (1'b1)
        push & ~pop: lvl_q <= lvl_q + LW'(1);
        pop & ~push: lvl_q <= lvl_q - LW'(1);
        default:     lvl_q <= lvl_q;
      endcase
    end
  end

  // Completing push and last-row pop in one cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt_q <= '0;
    end else begin
      unique case (1'b1)
        wr_done & ~rd_done: mcnt_q <= mcnt_q + LW'(1);
        rd_done & ~wr_done: mcnt_q <= mcnt_q - LW'(1);
        default:            mcnt_q <= mcnt_q;
      endcase
    end
  end

  mof_ram #(
    .WORD_W(WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(m2f_data),
    .raddr(rd_ptr),
    .rdata(f_data)
  );

endmodule

// File: tb/tb_matrix_out_fifo.sv
// Directed checks of matrix_out_fifo in cut-through and
// store-and-forward builds, plus a randomised scoreboard run.
module tb_matrix_out_fifo;

  logic        clk;
  logic        rst;

  logic [31:0] ct_d;
  logic        ct_v;
  logic        ct_rdy;
  logic [31:0] ct_q;
  logic        ct_fv;
  logic        ct_fl;
  logic        ct_fr;
  logic [3:0]  ct_lvl;
  logic [3:0]  ct_mc;

  logic [31:0] sf_d;
  logic        sf_v;
  logic        sf_rdy;
  logic [31:0] sf_q;
  logic        sf_fv;
  logic        sf_fl;
  logic        sf_fr;
  logic [3:0]  sf_lvl;
  logic [3:0]  sf_mc;

  int checks;
  int errors;

  matrix_out_fifo #(
    .WORD_W(32), .ROWS(4), .DEPTH(8), .STORE_FWD(0)
  ) u_ct (
    .clk(clk), .rst(rst),
    .m2f_data(ct_d), .m2f_valid(ct_v), .f2m_ready(ct_rdy),
    .f_data(ct_q), .f_valid(ct_fv), .f_last(ct_fl),
    .f_ready(ct_fr), .level(ct_lvl), .matrix_cnt(ct_mc)
  );

  matrix_out_fifo #(
    .WORD_W(32), .ROWS(4), .DEPTH(8), .STORE_FWD(1)
  ) u_sf (
    .clk(clk), .rst(rst),
    .m2f_data(sf_d), .m2f_valid(sf_v), .f2m_ready(sf_rdy),
    .f_data(sf_q), .f_valid(sf_fv), .f_last(sf_fl),
    .f_ready(sf_fr), .level(sf_lvl), .matrix_cnt(sf_mc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] t4_seq(input int j);
    return (j < 4) ? 32'hA000_0000 + 32'(j)
                   : 32'hB000_0000 + 32'(j - 4);
  endfunction

  logic [31:0] t1_rows [4];
  logic [31:0] sb [$];
  int          mlvl;
  int          mpush;
  int          mpop;
  int          cyc;
  logic        rv;
  logic        rf;
  logic [31:0] rd;
  logic        dpush;
  logic        dpop;

  initial begin
    checks = 0;
    errors = 0;
    t1_rows[0] = 32'h3020_1000;
    t1_rows[1] = 32'h3121_1101;
    t1_rows[2] = 32'h3222_1202;
    t1_rows[3] = 32'h3323_1303;
    rst = 1'b1;
    ct_d = '0; ct_v = 1'b0; ct_fr = 1'b0;
    sf_d = '0; sf_v = 1'b0; sf_fr = 1'b0;

    #1;
    chk("rst_fvalid", 32'(ct_fv), 0);
    chk("rst_flast", 32'(ct_fl), 0);
    chk("rst_ready", 32'(ct_rdy), 0);
    chk("rst_level", 32'(ct_lvl), 0);
    chk("rst_mcnt", 32'(ct_mc), 0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(ct_rdy), 1);
    chk("rel_sf_ready", 32'(sf_rdy), 1);

    // 1: cut-through, consumer always ready
    ct_fr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ct_v = 1'b1;
      ct_d = t1_rows[i];
      step();
      chk("t1_valid", 32'(ct_fv), 1);
      chk("t1_data", ct_q, t1_rows[i]);
      chk("t1_last", 32'(ct_fl), 32'(i == 3));
    end
    ct_v = 1'b0;
    chk("t1_mcnt", 32'(ct_mc), 1);
    step();
    chk("t1_empty", 32'(ct_fv), 0);
    chk("t1_mcnt0", 32'(ct_mc), 0);

    // 2: store-and-forward waits for a full matrix
    sf_fr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sf_v = 1'b1;
      sf_d = 32'h5000_0000 + 32'(i);
      step();
    end
    sf_v = 1'b0;
    repeat (5) step();
    chk("t2_hold_valid", 32'(sf_fv), 0);
    chk("t2_hold_mcnt", 32'(sf_mc), 0);
    chk("t2_hold_level", 32'(sf_lvl), 3);
    sf_v = 1'b1;
    sf_d = 32'h5000_0003;
    step();
    sf_v = 1'b0;
    chk("t2_rel_valid", 32'(sf_fv), 1);
    chk("t2_rel_mcnt", 32'(sf_mc), 1);
    for (int j = 0; j < 4; j++) begin
      chk("t2_data", sf_q, 32'h5000_0000 + 32'(j));
      chk("t2_last", 32'(sf_fl), 32'(j == 3));
      step();
    end
    chk("t2_drain_valid", 32'(sf_fv), 0);
    chk("t2_drain_level", 32'(sf_lvl), 0);
    chk("t2_drain_mcnt", 32'(sf_mc), 0);

    // 3: fill to full with consumer stalled
    ct_fr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ct_v = 1'b1;
      ct_d = 32'h3000_0000 + 32'(i);
      step();
    end
    chk("t3_full_level", 32'(ct_lvl), 8);
    chk("t3_full_ready", 32'(ct_rdy), 0);
    chk("t3_full_mcnt", 32'(ct_mc), 2);
    chk("t3_stall_data", ct_q, 32'h3000_0000);
    ct_d = 32'h3000_0008;
    step();
    step();
    chk("t3_held_level", 32'(ct_lvl), 8);
    chk("t3_stall_data2", ct_q, 32'h3000_0000);
    ct_fr = 1'b1;
    step();
    ct_fr = 1'b0;
    chk("t3_pop_level", 32'(ct_lvl), 7);
    chk("t3_pop_ready", 32'(ct_rdy), 1);
    step();
    ct_v = 1'b0;
    chk("t3_9th_level", 32'(ct_lvl), 8);
    chk("t3_9th_mcnt", 32'(ct_mc), 2);
    ct_fr = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk("t3_data", ct_q, 32'h3000_0000 + 32'(i));
      chk("t3_last", 32'(ct_fl), 32'(i % 4 == 3));
      step();
    end
    chk("t3_empty", 32'(ct_fv), 0);
    chk("t3_mcnt0", 32'(ct_mc), 0);

    // 4: steady push/pop at level 4 across pointer wrap
    ct_fr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ct_v = 1'b1;
      ct_d = t4_seq(i);
      step();
    end
    ct_fr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ct_d = t4_seq(k + 4);
      step();
      chk("t4_level", 32'(ct_lvl), 4);
      chk("t4_data", ct_q, t4_seq(k + 1));
    end
    ct_v = 1'b0;
    for (int j = 10; j < 14; j++) begin
      chk("t4_drain", ct_q, t4_seq(j));
      step();
    end
    chk("t4_empty_level", 32'(ct_lvl), 0);

    // 5: reset in the middle of a matrix
    ct_fr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ct_v = 1'b1;
      ct_d = 32'hC000_0000 + 32'(i);
      step();
    end
    ct_v = 1'b0;
    chk("t5_pre_level", 32'(ct_lvl), 2);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(ct_fv), 0);
    chk("t5_rst_level", 32'(ct_lvl), 0);
    chk("t5_rst_ready", 32'(ct_rdy), 0);
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      ct_v = 1'b1;
      ct_d = 32'hD000_0000 + 32'(i);
      step();
    end
    ct_v = 1'b0;
    chk("t5_level", 32'(ct_lvl), 4);
    chk("t5_mcnt", 32'(ct_mc), 1);
    ct_fr = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("t5_data", ct_q, 32'hD000_0000 + 32'(j));
      chk("t5_last", 32'(ct_fl), 32'(j == 3));
      step();
    end
    chk("t5_empty", 32'(ct_fv), 0);

    // 6: random traffic against a reference queue
    mlvl = 0;
    mpush = 0;
    mpop = 0;
    cyc = 0;
    while (mpop < 1000 && cyc < 20000) begin
      rv = (mpush < 1000) && ($urandom_range(3) != 0);
      rf = ($urandom_range(2) != 0);
      rd = $urandom;
      ct_v = rv;
      ct_d = rd;
      ct_fr = rf;
      chk("t6_ready", 32'(ct_rdy), 32'(mlvl != 8));
      chk("t6_valid", 32'(ct_fv), 32'(mlvl != 0));
      if (mlvl != 0) begin
        chk("t6_data", ct_q, sb[0]);
        chk("t6_last", 32'(ct_fl), 32'(mpop % 4 == 3));
      end
      dpush = rv && (mlvl != 8);
      dpop = rf && (mlvl != 0);
      step();
      if (dpop) begin
        void'(sb.pop_front());
        mpop++;
        mlvl--;
      end
      if (dpush) begin
        sb.push_back(rd);
        mpush++;
        mlvl++;
      end
      cyc++;
    end
    ct_v = 1'b0;
    chk("t6_all_rows", 32'(mpop), 1000);
    chk("t6_level", 32'(ct_lvl), 0);
    chk("t6_mcnt", 32'(ct_mc), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
